// File: rtl/model_sequencer_pkg.sv
// model_sequencer_pkg: shared state enum, select constant and default timing parameters
package model_sequencer_pkg;
  typedef enum logic [1:0] {IDLE, LEARN, RECOG} state_t;
  localparam logic [3:0] RANDOM_SEL = 4'd11;
  localparam int SLOT_CYC_DEF = 12;
  localparam int FRAME_SLOTS_DEF = 28;
  localparam int N_PAT_DEF = 10;
endpackage

// File: rtl/slot_timer.sv
// slot_timer: slot/frame timebase; ports clk, rst_n, en in; slot_tick, slot_idx, frame_done out
module slot_timer #(
  parameter int SLOT_CYC = 12,
  parameter int FRAME_SLOTS = 28
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       slot_tick,
  output logic [4:0] slot_idx,
  output logic       frame_done
);
  localparam int CW = SLOT_CYC > 1 ? $clog2(SLOT_CYC) : 1;
  logic [CW-1:0] cnt, cnt_n;
  logic [4:0] idx_n;
  logic wrap;
  always_comb begin
    wrap = en && cnt == CW'(SLOT_CYC - 1);
    cnt_n = !en ? cnt : wrap ? '0 : cnt + 1'b1;
    idx_n = !wrap ? slot_idx : slot_idx == 5'(FRAME_SLOTS - 1) ? '0 : slot_idx + 1'b1;
  end
  // tick/frame_done are registered from the next count so they line up with the terminal cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      slot_idx <= '0;
      slot_tick <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      cnt <= cnt_n;
      slot_idx <= idx_n;
      slot_tick <= cnt_n == CW'(SLOT_CYC - 1);
      frame_done <= cnt_n == CW'(SLOT_CYC - 1) && idx_n == 5'(FRAME_SLOTS - 1);
    end
  end
endmodule

// File: rtl/model_sequencer.sv
// model_sequencer: learn/recognition frame sequencer; ports clk, rst_n, learn_start, recog_req, recog_sel in; recog_ack, learn, in_cnt, slot_tick, slot_idx, frame_done, busy, learned, learn_cnt out
module model_sequencer
  import model_sequencer_pkg::*;
#(
  parameter int SLOT_CYC = SLOT_CYC_DEF,
  parameter int FRAME_SLOTS = FRAME_SLOTS_DEF,
  parameter int N_PAT = N_PAT_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       learn_start,
  input  logic       recog_req,
  input  logic [3:0] recog_sel,
  output logic       recog_ack,
  output logic       learn,
  output logic [3:0] in_cnt,
  output logic       slot_tick,
  output logic [4:0] slot_idx,
  output logic       frame_done,
  output logic       busy,
  output logic       learned,
  output logic [3:0] learn_cnt
);
  state_t state, state_n;
  logic pending, accept, last_pat, enter_learn, learn_done;
  assign busy = state != IDLE;
  slot_timer #(.SLOT_CYC(SLOT_CYC), .FRAME_SLOTS(FRAME_SLOTS)) u_timer (
    .clk(clk),
    .rst_n(rst_n),
    .en(busy),
    .slot_tick(slot_tick),
    .slot_idx(slot_idx),
    .frame_done(frame_done)
  );
  always_comb begin
    accept = state == IDLE && learned && !learn_start && recog_req
             && recog_sel >= 4'd1 && recog_sel <= RANDOM_SEL;
    last_pat = learn_cnt == 4'(N_PAT - 1);
    learn_done = state == LEARN && frame_done && last_pat;
    state_n = state == IDLE  ? (learn_start ? LEARN : accept ? RECOG : IDLE) :
              state == LEARN ? (learn_done ? IDLE : LEARN) :
              state == RECOG ? (!frame_done ? RECOG : (pending || learn_start) ? LEARN : IDLE) :
              IDLE;
    enter_learn = state_n == LEARN && state != LEARN;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      pending <= 1'b0;
      recog_ack <= 1'b0;
      learn <= 1'b0;
      in_cnt <= RANDOM_SEL;
      learn_cnt <= '0;
      learned <= 1'b0;
    end else begin
      state <= state_n;
      // a learn request during RECOG waits for the frame to end
      pending <= state == RECOG && !frame_done && (pending || learn_start);
      recog_ack <= accept;
      learn <= state_n == LEARN && (state != LEARN || frame_done);
      in_cnt <= enter_learn ? RANDOM_SEL : accept ? recog_sel : in_cnt;
      learn_cnt <= enter_learn ? '0 : (state == LEARN && frame_done) ? learn_cnt + 1'b1 : learn_cnt;
      learned <= enter_learn ? 1'b0 : learn_done ? 1'b1 : learned;
    end
  end
endmodule

// File: tb/tb_model_sequencer.sv
// tb_model_sequencer: self-checking bench for model_sequencer
module tb_model_sequencer;
  logic clk = 1'b0, rst_n = 1'b0, learn_start = 1'b0, recog_req = 1'b0;
  logic [3:0] recog_sel = 4'd0;
  logic recog_ack, learn, slot_tick, frame_done, busy, learned;
  logic [3:0] in_cnt, learn_cnt;
  logic [4:0] slot_idx;
  int n_tests = 0, n_fail = 0, n_learn = 0, n_fd = 0, n_tick = 0, n_ack = 0;
  typedef struct { logic [3:0] sel; logic ack; } vec_t;
  vec_t tbl[7];
  model_sequencer dut (
    .clk(clk), .rst_n(rst_n), .learn_start(learn_start), .recog_req(recog_req),
    .recog_sel(recog_sel), .recog_ack(recog_ack), .learn(learn), .in_cnt(in_cnt),
    .slot_tick(slot_tick), .slot_idx(slot_idx), .frame_done(frame_done), .busy(busy),
    .learned(learned), .learn_cnt(learn_cnt)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (learn) n_learn++;
    if (frame_done) n_fd++;
    if (slot_tick) n_tick++;
    if (recog_ack) n_ack++;
  end
  task automatic chk(string name, int act, int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic run_learn(input int inject_at);
    int k = 0, cyc = 0, last = 0, bad = 0;
    while (busy && cyc < 4000) begin
      if (learn) begin
        chk("learn_cnt_step", learn_cnt, k);
        if (k > 0) chk("learn_gap", cyc - last, 336);
        last = cyc;
        k++;
      end
      if (in_cnt != 4'd11) bad++;
      learn_start = (cyc == inject_at);
      tick;
      cyc++;
    end
    learn_start = 1'b0;
    chk("learn_len", cyc, 3360);
    chk("learn_pulses", k, 10);
    chk("learn_in_cnt", bad, 0);
    chk("learned_set", learned, 1);
    chk("learn_cnt_final", learn_cnt, 10);
    chk("busy_after_learn", busy, 0);
  endtask
  initial begin
    int n, a0, f0, t0;
    tbl[0] = '{sel: 4'd7,  ack: 1'b1};
    tbl[1] = '{sel: 4'd13, ack: 1'b0};
    tbl[2] = '{sel: 4'd0,  ack: 1'b0};
    tbl[3] = '{sel: 4'd1,  ack: 1'b1};
    tbl[4] = '{sel: 4'd11, ack: 1'b1};
    tbl[5] = '{sel: 4'd12, ack: 1'b0};
    tbl[6] = '{sel: 4'd15, ack: 1'b0};
    repeat (3) tick;
    chk("rst_busy", busy, 0);
    chk("rst_in_cnt", in_cnt, 11);
    chk("rst_learn_cnt", learn_cnt, 0);
    chk("rst_learned", learned, 0);
    chk("rst_slot_idx", slot_idx, 0);
    chk("rst_pulses", {learn, recog_ack, slot_tick, frame_done}, 0);
    @(negedge clk) rst_n = 1'b1;
    tick;
    // request before anything has been learned
    a0 = n_ack;
    n = 0;
    recog_sel = 4'd3;
    recog_req = 1'b1;
    repeat (1000) begin
      tick;
      if (busy) n++;
    end
    recog_req = 1'b0;
    chk("unlearned_ack", n_ack - a0, 0);
    chk("unlearned_busy", n, 0);
    learn_start = 1'b1;
    tick;
    learn_start = 1'b0;
    chk("learn_entry_in_cnt", in_cnt, 11);
    run_learn(-1);
    for (int i = 0; i < 7; i++) begin
      recog_sel = tbl[i].sel;
      recog_req = 1'b1;
      a0 = n_ack;
      f0 = n_fd;
      t0 = n_tick;
      tick;
      chk($sformatf("ack_sel%0d", tbl[i].sel), recog_ack, tbl[i].ack);
      if (tbl[i].ack) begin
        recog_req = 1'b0;
        chk($sformatf("in_cnt_sel%0d", tbl[i].sel), in_cnt, tbl[i].sel);
        n = 0;
        while (busy && n < 400) begin
          tick;
          n++;
        end
        chk("recog_len", n, 336);
        chk("recog_frame_done", n_fd - f0, 1);
        chk("recog_ticks", n_tick - t0, 28);
        chk("in_cnt_hold", in_cnt, tbl[i].sel);
      end else begin
        repeat (4) begin
          tick;
          chk($sformatf("busy_sel%0d", tbl[i].sel), busy, 0);
        end
        chk("no_ack_count", n_ack - a0, 0);
        recog_req = 1'b0;
      end
    end
    // learn_start beats a simultaneous recognition request
    a0 = n_ack;
    learn_start = 1'b1;
    recog_req = 1'b1;
    recog_sel = 4'd5;
    tick;
    learn_start = 1'b0;
    recog_req = 1'b0;
    chk("tie_ack", recog_ack, 0);
    chk("tie_learn", learn, 1);
    chk("tie_in_cnt", in_cnt, 11);
    chk("tie_learned_clr", learned, 0);
    run_learn(1000);
    chk("tie_ack_total", n_ack - a0, 0);
    // learn_start arriving mid-RECOG is deferred to the end of the frame
    recog_sel = 4'd2;
    recog_req = 1'b1;
    tick;
    recog_req = 1'b0;
    chk("pend_ack", recog_ack, 1);
    n = 0;
    while (slot_idx != 5'd10 && n < 400) begin
      tick;
      n++;
    end
    chk("pend_slot", slot_idx, 10);
    learn_start = 1'b1;
    tick;
    n++;
    learn_start = 1'b0;
    chk("pend_still_recog", {busy, learn}, 2);
    while (!frame_done && n < 400) begin
      tick;
      n++;
    end
    chk("pend_frame_len", n, 335);
    chk("pend_in_cnt", in_cnt, 2);
    tick;
    chk("pend_learn", learn, 1);
    chk("pend_in_cnt11", in_cnt, 11);
    chk("pend_busy", busy, 1);
    chk("pend_learn_cnt", learn_cnt, 0);
    // reset in the middle of learn frame 4
    n = 0;
    while (!(learn_cnt == 4'd3 && slot_idx == 5'd15) && n < 2000) begin
      tick;
      n++;
    end
    chk("rst_point", {learn_cnt, slot_idx}, {4'd3, 5'd15});
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_learn_cnt", learn_cnt, 0);
    chk("mid_rst_learned", learned, 0);
    chk("mid_rst_in_cnt", in_cnt, 11);
    chk("mid_rst_slot_idx", slot_idx, 0);
    chk("mid_rst_pulses", {learn, recog_ack, slot_tick, frame_done}, 0);
    f0 = n_fd;
    repeat (3) tick;
    @(negedge clk) rst_n = 1'b1;
    repeat (400) tick;
    chk("mid_rst_no_fd", n_fd - f0, 0);
    chk("mid_rst_idle", busy, 0);
    learn_start = 1'b1;
    tick;
    learn_start = 1'b0;
    chk("restart_learn", {busy, learn, in_cnt}, {1'b1, 1'b1, 4'd11});
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
